// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with an iterative multiply/divide engine.
// A multiply or divide takes WIDTH RUN cycles plus one FINISH cycle. HI/LO and
// the done_o pulse both appear on the edge that leaves FINISH.
// Optional feature macro: HILO_MADD_EN. When it is defined, op codes 8-11
// (MADD/MADDU/MSUB/MSUBU) accumulate the product into {HI,LO}. When it is not
// defined, those codes decode as NOP.
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic             op_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [3:0] OP_MTHI  = 4'd1;
    localparam logic [3:0] OP_MTLO  = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic                r_is_div;
    logic                r_neg_q;      // negate product / quotient
    logic                r_neg_r;      // negate remainder (dividend was negative)
    logic                r_div_zero;
    logic [WIDTH-1:0]    r_a_raw;      // original dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]    r_opnd;       // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0]  r_acc;        // {partial product, multiplier} or {remainder, quotient}

    // ---------------- request decode ----------------
    logic w_accept;
    logic w_is_mul;
    logic w_is_div;
    logic w_signed;
    logic w_a_neg;
    logic w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

`ifdef HILO_MADD_EN
    logic w_is_madd;
    logic w_madd_sub;
    logic r_is_acc;
    logic r_acc_sub;
    assign w_is_madd  = (op_i == 4'd8) || (op_i == 4'd9) || (op_i == 4'd10) || (op_i == 4'd11);
    assign w_madd_sub = (op_i == 4'd10) || (op_i == 4'd11);
    assign w_is_mul   = (op_i == OP_MULT) || (op_i == OP_MULTU) || w_is_madd;
    assign w_signed   = (op_i == OP_MULT) || (op_i == OP_DIV) || (op_i == 4'd8) || (op_i == 4'd10);
`else
    assign w_is_mul   = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign w_signed   = (op_i == OP_MULT) || (op_i == OP_DIV);
`endif

    assign w_accept = op_valid_i && (r_state == S_IDLE) && !flush_i;
    assign w_is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign w_a_neg  = w_signed && src_a_i[WIDTH-1];
    assign w_b_neg  = w_signed && src_b_i[WIDTH-1];
    // The most-negative value maps to itself, which is its correct unsigned magnitude.
    assign w_a_mag  = w_a_neg ? (~src_a_i + 1'b1) : src_a_i;
    assign w_b_mag  = w_b_neg ? (~src_b_i + 1'b1) : src_b_i;

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_div_next;

    // Shift-add: add the multiplicand when the multiplier LSB is set, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    // Restoring divide: shift in the next dividend bit and keep the subtraction if it did not borrow.
    assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // ---------------- result formation ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quot = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    // Pick the value written to HI/LO when FINISH completes. Signed overflow
    // (most-negative / -1) needs no special case: the magnitudes divide to
    // 2^(WIDTH-1) remainder 0, and with both signs negative no correction applies.
    always_comb begin
        w_hi_res = w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_hi_res = r_a_raw;
                w_lo_res = '1;
            end else begin
                w_hi_res = w_rem;
                w_lo_res = w_quot;
            end
        end
`ifdef HILO_MADD_EN
        else if (r_is_acc) begin
            {w_hi_res, w_lo_res} = r_acc_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
        end
`endif
    end

    // Control FSM, HI/LO registers and engine state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
`ifdef HILO_MADD_EN
            r_is_acc   <= 1'b0;
            r_acc_sub  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (op_i == OP_MTHI) r_hi <= src_a_i;
                        if (op_i == OP_MTLO) r_lo <= src_a_i;
                        if (w_is_mul || w_is_div) begin
                            r_state    <= S_RUN;
                            r_cnt      <= '0;
                            r_is_div   <= w_is_div;
                            r_neg_q    <= w_a_neg ^ w_b_neg;
                            r_neg_r    <= w_a_neg;
                            r_div_zero <= w_is_div && (src_b_i == '0);
                            r_a_raw    <= src_a_i;
                            r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
                            r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
`ifdef HILO_MADD_EN
                            r_is_acc   <= w_is_madd;
                            r_acc_sub  <= w_madd_sub;
`endif
                        end
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    if (!flush_i) begin
                        r_hi   <= w_hi_res;
                        r_lo   <= w_lo_res;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_ready_o = (r_state == S_IDLE);
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = r_done;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized + directed bench for hilo_muldiv (WIDTH=32) against an
// arithmetic reference model of HI/LO.
module tb_hilo_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid_i = 1'b0;
    logic [3:0]    op_i = 4'd0;
    logic [W-1:0]  src_a_i = '0;
    logic [W-1:0]  src_b_i = '0;
    logic          flush_i = 1'b0;
    logic          op_ready_o;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] ref_hi = '0;
    logic [W-1:0] ref_lo = '0;

    hilo_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
        .op_ready_o(op_ready_o), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] op);
`ifdef HILO_MADD_EN
        return (op >= 4'd3 && op <= 4'd6) || (op >= 4'd8 && op <= 4'd11);
`else
        return (op >= 4'd3 && op <= 4'd6);
`endif
    endfunction

    // Reference: what HI/LO must hold after the operation completes.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int          ia, ib;
        longint      sp;
        logic [63:0] up;
        ia = a;
        ib = b;
        sp = longint'(ia) * longint'(ib);
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1: ref_hi = a;
            4'd2: ref_lo = a;
            4'd3: {ref_hi, ref_lo} = sp;
            4'd4: {ref_hi, ref_lo} = up;
            4'd5: begin
                if (b == 0) begin ref_lo = '1; ref_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin ref_lo = a; ref_hi = '0; end
                else begin ref_lo = ia / ib; ref_hi = ia % ib; end
            end
            4'd6: begin
                if (b == 0) begin ref_lo = '1; ref_hi = a; end
                else begin ref_lo = a / b; ref_hi = a % b; end
            end
`ifdef HILO_MADD_EN
            4'd8:  {ref_hi, ref_lo} = {ref_hi, ref_lo} + sp;
            4'd9:  {ref_hi, ref_lo} = {ref_hi, ref_lo} + up;
            4'd10: {ref_hi, ref_lo} = {ref_hi, ref_lo} - sp;
            4'd11: {ref_hi, ref_lo} = {ref_hi, ref_lo} - up;
`endif
            default: ;
        endcase
    endtask

    // Wait (bounded) for done_o; flags any cycle where the engine looked idle early.
    task automatic wait_done(output int cycles, output bit bad_hs);
        cycles = 0;
        bad_hs = 0;
        while (done_o !== 1'b1 && cycles < 100) begin
            if (op_ready_o !== 1'b0 || busy_o !== 1'b1) bad_hs = 1;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // One complete transaction: issue, wait for completion, compare with the model.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int cycles;
        bit bad_hs;
        op_valid_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        model(op, a, b);
        if (is_multi(op)) begin
            wait_done(cycles, bad_hs);
            check("latency", 64'(cycles), 64'(W + 1));
            check("busy_handshake", 64'(bad_hs), 64'd0);
            check("ready_after_done", {63'd0, op_ready_o}, 64'd1);
        end else begin
            check("no_done_single", {63'd0, done_o}, 64'd0);
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (ref %h %h)", op, a, b, hi_o, lo_o, ref_hi, ref_lo);
        check("hi", {32'd0, hi_o}, {32'd0, ref_hi});
        check("lo", {32'd0, lo_o}, {32'd0, ref_lo});
        if (is_multi(op)) begin
            @(posedge clk); #1;
            check("done_one_cycle", {63'd0, done_o}, 64'd0);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Abort an in-flight DIV on RUN cycle 10 with flush_i (use_rst=0) or rst (use_rst=1).
    task automatic abort_test(input bit use_rst);
        int seen_done;
        run_op(4'd1, 32'hAAAA_0000, 32'd0);
        run_op(4'd2, 32'h0000_5555, 32'd0);
        op_valid_i = 1'b1; op_i = 4'd5; src_a_i = 32'd1000; src_b_i = 32'd3;
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        if (use_rst) rst = 1'b1; else flush_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush_i = 1'b0;
        if (use_rst) begin ref_hi = '0; ref_lo = '0; end
        $display("abort use_rst=%0d -> hi=%h lo=%h ready=%0b", use_rst, hi_o, lo_o, op_ready_o);
        check("abort_ready", {63'd0, op_ready_o}, 64'd1);
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        seen_done = 0;
        repeat (40) begin
            if (done_o === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_hi", {32'd0, hi_o}, {32'd0, ref_hi});
        check("abort_lo", {32'd0, lo_o}, {32'd0, ref_lo});
    endtask

    initial begin
        int cycles;
        bit bad_hs;
        logic [3:0] rop;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_hi", {32'd0, hi_o}, 64'd0);
        check("rst_lo", {32'd0, lo_o}, 64'd0);
        check("rst_ready", {63'd0, op_ready_o}, 64'd1);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);

        // Directed cases
        run_op(4'd1, 32'h1234_5678, 32'd0);
        run_op(4'd2, 32'h9ABC_DEF0, 32'd0);
        run_op(4'd3, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_const", {32'd0, hi_o}, 64'hFFFF_FFFF);
        check("mult_lo_const", {32'd0, lo_o}, 64'hFFFF_FFFA);
        run_op(4'd4, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi_const", {32'd0, hi_o}, 64'h2);
        run_op(4'd5, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", {32'd0, lo_o}, 64'hFFFF_FFFD);
        check("div_hi_const", {32'd0, hi_o}, 64'hFFFF_FFFF);
        run_op(4'd6, 32'd100, 32'd7);
        run_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", {32'd0, lo_o}, 64'h8000_0000);
        run_op(4'd6, 32'd5, 32'd0);
        check("divu_zero_hi", {32'd0, hi_o}, 64'd5);
        run_op(4'd5, 32'hFFFF_FFF0, 32'd0);
        run_op(4'd0, 32'h1111_1111, 32'd2);

        // flush_i while idle drops the request
        op_valid_i = 1'b1; op_i = 4'd1; src_a_i = 32'hDEAD_BEEF; flush_i = 1'b1;
        @(posedge clk); #1;
        op_valid_i = 1'b0; flush_i = 1'b0;
        check("idle_flush_hi", {32'd0, hi_o}, {32'd0, ref_hi});

        // Back-to-back: valid held high, second op waits for IDLE
        op_valid_i = 1'b1; op_i = 4'd4; src_a_i = 32'd12345; src_b_i = 32'd678;
        @(posedge clk); #1;
        model(4'd4, 32'd12345, 32'd678);
        op_i = 4'd6; src_a_i = 32'd100; src_b_i = 32'd7;
        wait_done(cycles, bad_hs);
        check("b2b_first_latency", 64'(cycles), 64'(W + 1));
        check("b2b_ready_low", 64'(bad_hs), 64'd0);
        check("b2b_first_lo", {32'd0, lo_o}, {32'd0, ref_lo});
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        model(4'd6, 32'd100, 32'd7);
        wait_done(cycles, bad_hs);
        $display("b2b second -> hi=%h lo=%h cycles=%0d", hi_o, lo_o, cycles);
        check("b2b_second_latency", 64'(cycles), 64'(W + 1));
        check("b2b_second_hi", {32'd0, hi_o}, 64'd2);
        check("b2b_second_lo", {32'd0, lo_o}, 64'd14);

        // Aborts
        abort_test(1'b0);
        abort_test(1'b1);

        // Accumulate ops (or their NOP decoding)
        run_op(4'd1, 32'd0, 32'd0);
        run_op(4'd2, 32'hFFFF_FFFF, 32'd0);
        run_op(4'd9, 32'd2, 32'd3);
`ifdef HILO_MADD_EN
        check("maddu_hi", {32'd0, hi_o}, 64'd1);
        check("maddu_lo", {32'd0, lo_o}, 64'd5);
        run_op(4'd11, 32'd1, 32'd6);
        check("msubu_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);
`else
        check("nop9_hi", {32'd0, hi_o}, 64'd0);
        check("nop9_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);
`endif

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: rop = 4'd1;
                1: rop = 4'd2;
                2: rop = 4'd3;
                3: rop = 4'd4;
                4: rop = 4'd5;
                5: rop = 4'd6;
                6: rop = 4'(8 + $urandom_range(0, 3));
                default: rop = 4'(($urandom_range(0, 1) == 0) ? 7 : 12 + $urandom_range(0, 3));
            endcase
            run_op(rop, pick(), pick());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Parametrised HI/LO register file with an attached iterative multiply/divide engine for the integer pipeline.
- Sits beside the EX stage.
- Accepts MTHI/MTLO writes and multi-cycle MULT/DIV operations through a valid/ready handshake.
- Holds HI/LO for MFHI/MFLO reads and supports pipeline flush of an in-flight operation.

Parameters:
- WIDTH, 32: data width of each operand and of each of HI and LO.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- op_valid_i  input  1  operation request valid
- op_i  input  4  operation code: 0 NOP, 1 MTHI, 2 MTLO, 3 MULT, 4 MULTU, 5 DIV, 6 DIVU, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; all other codes NOP
- src_a_i  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO data)
- src_b_i  input  WIDTH  operand B (multiplier / divisor)
- flush_i  input  1  abort in-flight operation / drop request this cycle
- op_ready_o  output  1  engine can accept an operation this cycle
- busy_o  output  1  multi-cycle operation in progress
- done_o  output  1  one-cycle pulse when HI/LO are written by a MUL/DIV/MADD-class op
- hi_o  output  WIDTH  current HI register
- lo_o  output  WIDTH  current LO register

Behaviour:
- Reset (rst=1 at posedge): state IDLE, HI=0, LO=0, counter=0, done_o=0, busy_o=0, op_ready_o=1 after the edge. Reset mid-operation discards the operation.
- Accept condition: op_valid_i && op_ready_o && !flush_i. op_ready_o = (state==IDLE). flush_i in IDLE drops the request.
- Single-cycle ops (in IDLE, stay in IDLE):
  - MTHI: HI<=src_a_i; LO unchanged.
  - MTLO: LO<=src_a_i; HI unchanged.
  - No done_o pulse for MTHI/MTLO.
  - NOP: accepted, no effect.
- Multi-cycle ops: IDLE -> RUN -> FINISH -> IDLE.
  - Accept edge: latch operand magnitudes, result-sign flags and op; counter<=0; state<=RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles. Leave RUN when counter==WIDTH-1.
  - FINISH: apply sign correction, write HI/LO, done_o=1 for this cycle only. Next edge -> IDLE.
  - Latency: op accepted at edge E; new HI/LO visible after edge E+WIDTH+1; op_ready_o high again after that edge.
  - busy_o=1 in RUN and FINISH.
- Multiply: {HI,LO} = 2*WIDTH-bit product. Signed ops use two's-complement operands; the product is negated when the operand signs differ.
- Divide: LO=quotient, HI=remainder.
  - Signed: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = src_a_i unchanged.
  - Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- Flush during RUN or FINISH: engine returns to IDLE on that edge. HI/LO are not written and done_o is forced to 0.
- HI/LO change only via MTHI/MTLO, FINISH, or reset.

Optional Feature:
- Macro: HILO_MADD_EN.
- Defined: ops 8-11 run the multiply sequence. In FINISH, {HI,LO} <= {HI,LO} + product (MADD/MADDU) or {HI,LO} - product (MSUB/MSUBU). Arithmetic is modulo 2^(2*WIDTH), using the HI/LO values current at FINISH.
- Not defined: codes 8-11 decode as NOP and no accumulate logic is built.

Test Plan (WIDTH=32):
- Reset, then MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0, done_o never asserted.
- MULT 0xFFFFFFFE x 0x00000003 -> done_o pulse exactly 33 cycles after the accept edge; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. Back-to-back op_valid_i held high -> op_ready_o low during RUN/FINISH and second op accepted only after return to IDLE.
- Preload HI=0xAAAA0000, LO=0x5555; DIV issued; flush_i at RUN cycle 10 -> no done_o, HI/LO unchanged, op_ready_o=1 next cycle. Repeat with rst instead of flush_i -> HI=LO=0.
- With HILO_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 2x3 -> HI=1, LO=5. Then MSUBU 1x6 -> HI=0, LO=0xFFFFFFFF. Without the macro, op 9 -> no change, no done_o.
